load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Bridges the execute stage to the data memory. Accepts one load/store per
//  request using byte addresses, then drives the word-addressed memory port
//  (en/write_enable/byte_enable/byte_select/addr/data_in).
//  Captures read data, sign/zero-extends byte loads, flags faulting accesses
//  and returns a one-cycle response pulse. Sits between execute and memory.
// PARAMETERS
//  MEM_WORDS  64  words implemented in memory; word addr >= MEM_WORDS faults
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst             in   1   asynchronous, active-high reset
//  req_valid       in   1   request present
//  req_ready       out  1   unit idle; request accepted when valid&&ready
//  req_write       in   1   1=store, 0=load
//  req_byte        in   1   1=byte access, 0=word access
//  req_signed      in   1   byte loads: 1=sign-extend, 0=zero-extend
//  req_addr        in   16  byte address
//  req_wdata       in   16  store data (byte store uses [7:0])
//  resp_valid      out  1   one-cycle completion pulse; no backpressure
//  resp_rdata      out  16  load result, valid with resp_valid; 0 for stores/faults
//  resp_fault      out  1   misaligned word access or out of range, valid with resp_valid
//  wait_cycles     out  16  saturating count of cycles stalled by mem_wait
//  mem_en          out  1   memory enable
//  mem_we          out  1   memory write_enable
//  mem_byte_enable out  1   memory byte_enable
//  mem_byte_select out  1   memory byte_select (1=high byte)
//  mem_addr        out  16  word address = {1'b0, req_addr[15:1]}
//  mem_wdata       out  16  word: req_wdata; byte: {8'h00, req_wdata[7:0]}
//  mem_rdata       in   16  memory data_out, valid the cycle after the enabled edge
//  mem_wait        in   1   memory stall; hold current state and outputs
// BEHAVIOUR
//  Reset (async): state IDLE. All outputs 0 except req_ready=1. Latched
//   request and wait_cycles cleared.
//  Reset mid-op: the unit goes straight to IDLE, mem_en drops immediately and
//   no response is emitted. A store in ISSUE is not written.
//  States: IDLE, ISSUE, CAPTURE, RESP.
//   IDLE:    req_ready=1. On accept, latch the request and compute the fault:
//            (!req_byte && req_addr[0]) || (req_addr[15:1] >= MEM_WORDS).
//            Fault -> RESP. Otherwise -> ISSUE.
//   ISSUE:   mem_en=1, mem_we=req_write. If mem_wait, stay in ISSUE.
//            Otherwise a store goes to RESP and a load goes to CAPTURE.
//   CAPTURE: mem_en=0. If mem_wait, stay. Otherwise register resp_rdata:
//            word load = mem_rdata; byte load = req_signed ?
//            {{8{mem_rdata[7]}}, mem_rdata[7:0]} : {8'h00, mem_rdata[7:0]}.
//            Then -> RESP.
//   RESP:    resp_valid=1 for exactly one cycle, then -> IDLE. req_ready=0.
//  Memory-port hold: mem_addr, byte_enable, byte_select and wdata are driven
//   from the latched request in ISSUE and CAPTURE and held stable, because
//   memory registers byte_enable/select every clock. They are 0 in IDLE/RESP.
//  Latency from accept edge: load resp_valid 3 cycles later; store 2;
//   fault 1 (no memory access). Each mem_wait cycle adds 1.
//  wait_cycles: +1 each cycle mem_wait=1 in ISSUE/CAPTURE; saturates at 16'hFFFF.
//  A new request cannot be accepted in RESP; next acceptance earliest in IDLE.
//  resp_rdata/resp_fault hold their values until the next RESP.
// STRUCTURE
//  Shared include lsu_defs.vh: state encodings (2-bit), LSU_IDLE/ISSUE/
//   CAPTURE/RESP.
//  Sub-module lsu_load_format: combinational byte/word select and sign/zero
//   extension, reused by the writeback path.
//  Verify against the existing memory model (MEM_WORDS=64) plus a mem_wait
//   stub.
// TESTING
//  1 Store word 0xBEEF @0x0010, then load word @0x0010 -> mem_addr=0x0008,
//    store done after 2 cycles, load after 3, resp_rdata=0xBEEF, fault=0.
//  2 Store byte 0x80 @0x0011, then signed byte load @0x0011 -> byte_select=1,
//    rdata=0xFF80. Unsigned byte load -> 0x0080. Word @0x0010 -> 0x80EF.
//  3 Load word @0x0003 -> resp_fault=1, rdata=0, mem_en never asserted,
//    resp_valid 1 cycle after accept.
//  4 Store word @0x0080 (word 64) -> fault=1, memory contents unchanged.
//  5 mem_wait high 3 cycles in ISSUE on a load -> mem outputs held stable,
//    resp_valid at +6, wait_cycles=3.
//  6 Assert rst during ISSUE of a store 0x1234 @0x0004 -> outputs 0,
//    req_ready=1, no resp_valid, load @0x0004 afterwards returns the old value.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : load_store_unit_pkg
// Brief  : FSM state encoding and fault helper for the load/store unit.
// Rev    : 1.0
// ============================================================================
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE    = 2'd0,
        LSU_ISSUE   = 2'd1,
        LSU_CAPTURE = 2'd2,
        LSU_RESP    = 2'd3
    } lsu_state_t;

    // Misaligned word access, or word address beyond implemented memory.
    function automatic logic lsu_fault(input logic        is_byte,
                                       input logic [15:0] addr,
                                       input logic [15:0] mem_words);
        return (!is_byte && addr[0]) || ({1'b0, addr[15:1]} >= mem_words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_load_format.sv
`default_nettype none
// ============================================================================
// Module : load_store_unit_load_format
// Brief  : Word pass-through or byte sign/zero extension of memory read data.
// Rev    : 1.0
// ============================================================================
module load_store_unit_load_format (
    input  logic [15:0] i_rdata,
    input  logic        i_byte,
    input  logic        i_signed,
    output logic [15:0] o_data
);

    // The memory already steers the selected byte onto [7:0].
    always_comb begin
        o_data = i_rdata;
        if (i_byte) begin
            o_data = {(i_signed ? {8{i_rdata[7]}} : 8'h00), i_rdata[7:0]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : load_store_unit
// Brief  : Execute-to-data-memory bridge: byte-addressed requests in, word port out.
// Rev    : 1.0
// ============================================================================
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic        i_req_byte,
    input  logic        i_req_signed,
    input  logic [15:0] i_req_addr,
    input  logic [15:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [15:0] o_resp_rdata,
    output logic        o_resp_fault,
    output logic [15:0] o_wait_cycles,
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic        o_mem_byte_enable,
    output logic        o_mem_byte_select,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_wait
);

    import load_store_unit_pkg::*;

    localparam logic [15:0] c_MEM_WORDS = 16'(MEM_WORDS);

    lsu_state_t  r_state;
    lsu_state_t  w_next;
    logic        r_write;
    logic        r_byte;
    logic        r_signed;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_resp_rdata;
    logic        r_resp_fault;
    logic [15:0] r_wait_cycles;

    logic        w_accept;
    logic        w_fault;
    logic        w_active;
    logic [15:0] w_load_data;

    assign w_accept = i_req_valid && (r_state == LSU_IDLE);
    assign w_fault  = lsu_fault(i_req_byte, i_req_addr, c_MEM_WORDS);
    assign w_active = (r_state == LSU_ISSUE) || (r_state == LSU_CAPTURE);

    load_store_unit_load_format u_load_format (
        .i_rdata  (i_mem_rdata),
        .i_byte   (r_byte),
        .i_signed (r_signed),
        .o_data   (w_load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= LSU_IDLE;
            r_write       <= 1'b0;
            r_byte        <= 1'b0;
            r_signed      <= 1'b0;
            r_addr        <= 16'h0000;
            r_wdata       <= 16'h0000;
            r_resp_rdata  <= 16'h0000;
            r_resp_fault  <= 1'b0;
            r_wait_cycles <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write  <= i_req_write;
                r_byte   <= i_req_byte;
                r_signed <= i_req_signed;
                r_addr   <= i_req_addr;
                r_wdata  <= i_req_wdata;
            end
            if (w_active && i_mem_wait && (r_wait_cycles != 16'hFFFF)) begin
                r_wait_cycles <= r_wait_cycles + 16'd1;
            end
            // Response fields change only on entry to RESP and hold afterwards.
            if ((w_next == LSU_RESP) && (r_state != LSU_RESP)) begin
                r_resp_fault <= (r_state == LSU_IDLE) ? w_fault : 1'b0;
                r_resp_rdata <= (r_state == LSU_CAPTURE) ? w_load_data : 16'h0000;
            end
        end
    end

    always_comb begin
        w_next            = r_state;
        o_req_ready       = 1'b0;
        o_resp_valid      = 1'b0;
        o_mem_en          = 1'b0;
        o_mem_we          = 1'b0;
        o_mem_byte_enable = 1'b0;
        o_mem_byte_select = 1'b0;
        o_mem_addr        = 16'h0000;
        o_mem_wdata       = 16'h0000;

        // Port fields stay stable across ISSUE and CAPTURE for the memory's own registers.
        if (w_active) begin
            o_mem_byte_enable = r_byte;
            o_mem_byte_select = r_byte && r_addr[0];
            o_mem_addr        = {1'b0, r_addr[15:1]};
            o_mem_wdata       = r_byte ? {8'h00, r_wdata[7:0]} : r_wdata;
        end

        case (r_state)
            LSU_IDLE: begin
                o_req_ready = 1'b1;
                if (w_accept) begin
                    w_next = w_fault ? LSU_RESP : LSU_ISSUE;
                end
            end
            LSU_ISSUE: begin
                o_mem_en = 1'b1;
                o_mem_we = r_write;
                if (!i_mem_wait) begin
                    w_next = r_write ? LSU_RESP : LSU_CAPTURE;
                end
            end
            LSU_CAPTURE: begin
                if (!i_mem_wait) begin
                    w_next = LSU_RESP;
                end
            end
            LSU_RESP: begin
                o_resp_valid = 1'b1;
                w_next       = LSU_IDLE;
            end
            default: w_next = LSU_IDLE;
        endcase
    end

    assign o_resp_rdata  = r_resp_rdata;
    assign o_resp_fault  = r_resp_fault;
    assign o_wait_cycles = r_wait_cycles;

endmodule
`default_nettype wire
